// File: rtl/fifo_stream_pop.sv
// fifo_stream_pop: FIFO read-side adapter presenting a registered valid/ready stream via head+skid buffer
module fifo_stream_pop #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             fifo_read,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [1:0]       occ
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] head, skid, head_n, skid_n;
  logic pop, push;
  assign fifo_read = ~fifo_empty & ~flush & ~reset & (state != TWO);
  assign push = fifo_read;
  assign pop = m_valid & m_ready;
  assign m_valid = state != EMPTY;
  assign m_data = head;
  assign occ = state;
  always_comb begin
    state_n = flush ? EMPTY : state_t'(state + {1'b0, push} - {1'b0, pop});
    head_n = (push & (state == EMPTY | pop)) ? fifo_rdata : (pop & state == TWO) ? skid : head;
    skid_n = (push & ~pop & state == ONE) ? fifo_rdata : skid;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      head <= '0;
      skid <= '0;
    end else begin
      state <= state_n;
      head <= head_n;
      skid <= skid_n;
    end
  end
endmodule

// File: tb/tb_fifo_stream_pop.sv
// tb_fifo_stream_pop: scoreboard bench driving a FIFO model into fifo_stream_pop
module tb_fifo_stream_pop;
  logic clk = 0;
  logic reset, flush, fifo_empty, fifo_read, m_valid, m_ready;
  logic [31:0] fifo_rdata, m_data;
  logic [1:0] occ;
  int n_cmp = 0, n_err = 0, pops = 0;
  logic [31:0] q[$], mbuf[$];
  logic rst_seen;
  always #5 clk = ~clk;
  fifo_stream_pop #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata), .fifo_read(fifo_read), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .occ(occ)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic r, input logic f, input logic rdy, input logic gate);
    logic er, pop;
    @(negedge clk);
    reset = r;
    flush = f;
    m_ready = rdy;
    fifo_empty = !(gate && q.size() > 0);
    fifo_rdata = fifo_empty ? '0 : q[0];
    #1;
    er = !fifo_empty && !f && !r && mbuf.size() < 2;
    pop = mbuf.size() > 0 && rdy;
    chk("occ", 32'(occ), 32'(mbuf.size()));
    chk("m_valid", 32'(m_valid), 32'(mbuf.size() > 0));
    chk("fifo_read", 32'(fifo_read), 32'(er));
    if (mbuf.size() > 0) chk("m_data", m_data, mbuf[0]);
    else if (rst_seen) chk("m_data_rst", m_data, 32'h0);
    @(posedge clk);
    if (r) begin
      mbuf.delete();
      rst_seen = 1;
    end else if (f) begin
      mbuf.delete();
    end else begin
      if (pop) void'(mbuf.pop_front());
      if (er) begin
        mbuf.push_back(q.pop_front());
        pops++;
        rst_seen = 0;
      end
    end
  endtask
  initial begin
    reset = 1;
    flush = 0;
    m_ready = 1;
    fifo_empty = 1;
    fifo_rdata = '0;
    rst_seen = 1;
    q = '{32'h11, 32'h22, 32'h33, 32'h44};
    repeat (2) @(posedge clk);
    repeat (2) cyc(1, 0, 1, 1);
    pops = 0;
    repeat (8) cyc(0, 0, 1, 1);
    chk("stream_pops", 32'(pops), 32'd4);
    q = '{32'h11, 32'h22, 32'h33, 32'h44};
    pops = 0;
    repeat (5) cyc(0, 0, 0, 1);
    chk("stall_pops", 32'(pops), 32'd2);
    repeat (8) cyc(0, 0, 1, 1);
    chk("stall_drain", 32'(q.size()), 32'd0);
    q = '{32'hA, 32'hB};
    repeat (3) cyc(0, 0, 0, 1);
    cyc(0, 1, 1, 1);
    repeat (3) cyc(0, 0, 1, 1);
    for (int i = 0; i < 60; i++) begin
      if (i % 2 == 0) q.push_back((i % 4 == 0) ? 32'h5 : 32'h6);
      cyc(0, 0, 1'($urandom_range(0, 1)), 1'(i % 2));
    end
    repeat (8) cyc(0, 0, 1, 1);
    chk("alt_drain", 32'(q.size()), 32'd0);
    q = '{32'h77, 32'h88, 32'h99};
    repeat (3) cyc(0, 0, 0, 1);
    cyc(1, 0, 1, 1);
    repeat (4) cyc(0, 0, 1, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
